// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between fetch
// and the loader; fetch has priority, a starvation counter protects the loader.
module imem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_f_req,
  input  logic [ADDR_WIDTH-1:0] i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  output logic [31:0]           o_f_rdata,
  input  logic                  i_l_req,
  input  logic                  i_l_wren,
  input  logic [ADDR_WIDTH-1:0] i_l_addr,
  input  logic [31:0]           i_l_wdata,
  input  logic [3:0]            i_l_bmask,
  input  logic                  i_l_lock,
  output logic                  o_l_gnt,
  output logic                  o_l_rvalid,
  output logic [31:0]           o_l_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_bmask,
  output logic                  o_mem_wren,
  input  logic [31:0]           i_mem_rdata,
  output logic [CNT_WIDTH-1:0]  o_conflict_cnt
);

  typedef enum logic {
    SHARED = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [3:0]           wait_q, wait_d;
  logic                 f_pend_q, f_pend_d;
  logic                 l_pend_q, l_pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 starved;
  logic                 shared;

  assign starved = (wait_q == WAIT_MAX);
  assign shared  = (state_q == SHARED);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= SHARED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHARED: if (o_l_gnt && i_l_lock) state_d = LOCKED;
      LOCKED: if (!i_l_lock) state_d = SHARED;
      default: state_d = SHARED;
    endcase
  end

  // Locked mode blocks fetch even while the loader is idle.
  always_comb begin
    o_f_gnt = 1'b0;
    o_l_gnt = 1'b0;
    unique case (1'b1)
      !shared: o_l_gnt = i_l_req;
      shared && i_l_req && (starved || !i_f_req):
        o_l_gnt = 1'b1;
      default: o_f_gnt = i_f_req;
    endcase
  end

  always_comb begin
    o_mem_addr  = i_f_addr;
    o_mem_wdata = 32'd0;
    o_mem_bmask = 4'd0;
    o_mem_wren  = 1'b0;
    if (o_l_gnt) begin
      o_mem_addr  = i_l_addr;
      o_mem_wdata = i_l_wdata;
      o_mem_bmask = i_l_bmask;
      o_mem_wren  = i_l_wren;
    end
  end

  always_comb begin
    wait_d = 4'd0;
    if (i_l_req && !o_l_gnt) begin
      wait_d = starved ? wait_q : wait_q + 4'd1;
    end
    f_pend_d = o_f_gnt;
    l_pend_d = o_l_gnt && !i_l_wren;
    cnt_d    = cnt_q;
    if (i_f_req && !o_f_gnt && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wait_q   <= 4'd0;
      f_pend_q <= 1'b0;
      l_pend_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wait_q   <= wait_d;
      f_pend_q <= f_pend_d;
      l_pend_q <= l_pend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_f_rvalid     = f_pend_q;
  assign o_l_rvalid     = l_pend_q;
  assign o_f_rdata      = i_mem_rdata;
  assign o_l_rdata      = i_mem_rdata;
  assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: table vectors, directed corner sequences and random
// traffic checked against a behavioural arbiter and memory model.
module tb_imem_arbiter;
  localparam int AW = 16;
  localparam int MW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt, f_rv;
  logic [31:0]   f_rd;
  logic          l_req, l_wren, l_lock;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata;
  logic [3:0]    l_bmask;
  logic          l_gnt, l_rv;
  logic [31:0]   l_rd;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_bmask;
  logic          mem_wren;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_f_req(f_req), .i_f_addr(f_addr),
    .o_f_gnt(f_gnt), .o_f_rvalid(f_rv), .o_f_rdata(f_rd),
    .i_l_req(l_req), .i_l_wren(l_wren), .i_l_addr(l_addr),
    .i_l_wdata(l_wdata), .i_l_bmask(l_bmask), .i_l_lock(l_lock),
    .o_l_gnt(l_gnt), .o_l_rvalid(l_rv), .o_l_rdata(l_rd),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_bmask(mem_bmask), .o_mem_wren(mem_wren),
    .i_mem_rdata(mem_rdata), .o_conflict_cnt(cnt)
  );

  function automatic logic [31:0] init_word(int i);
    case (i)
      0: return 32'h0000_0011;
      1: return 32'h0000_0022;
      2: return 32'h0000_0033;
      4: return 32'hAABB_CCDD;
      default: return {8'(i), 8'hA5, 8'(255 - i), 8'h3C};
    endcase
  endfunction

  // Synchronous-read memory; reset reloads the known image.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_bmask[b])
          mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= mem[mem_addr[7:2]];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model state
  bit          m_valid = 0;
  bit          m_locked = 0;
  int          m_wait = 0;
  int          m_cnt = 0;
  bit          m_fp = 0;
  bit          m_lp = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_mem [64];

  // Samples taken mid-cycle for directed checks
  logic          s_fg, s_lg, s_frv, s_lrv, s_wren;
  logic [31:0]   s_frd, s_lrd;
  logic [CW-1:0] s_cnt;

  task automatic drive(bit fr, logic [AW-1:0] fa, bit lr, bit lw,
                       logic [AW-1:0] la, logic [31:0] wd,
                       logic [3:0] bm, bit lk);
    f_req = fr; f_addr = fa; l_req = lr; l_wren = lw;
    l_addr = la; l_wdata = wd; l_bmask = bm; l_lock = lk;
  endtask

  task automatic tick();
    bit ef, el;
    logic [AW-1:0] sel;
    @(negedge clk);
    if (m_locked) begin
      el = l_req;
      ef = 1'b0;
    end else begin
      el = l_req && (m_wait == MW || !f_req);
      ef = f_req && !el;
    end
    sel = el ? l_addr : f_addr;
    s_fg = f_gnt; s_lg = l_gnt; s_frv = f_rv; s_lrv = l_rv;
    s_frd = f_rd; s_lrd = l_rd; s_cnt = cnt; s_wren = mem_wren;
    if (m_valid) begin
      chk("f_gnt", 64'(f_gnt), 64'(ef));
      chk("l_gnt", 64'(l_gnt), 64'(el));
      chk("mem_addr", 64'(mem_addr), 64'(sel));
      chk("mem_wren", 64'(mem_wren), 64'(el && l_wren));
      chk("mem_bmask", 64'(mem_bmask), 64'(el ? l_bmask : 4'd0));
      chk("mem_wdata", 64'(mem_wdata), 64'(el ? l_wdata : 32'd0));
      chk("f_rvalid", 64'(f_rv), 64'(m_fp));
      chk("l_rvalid", 64'(l_rv), 64'(m_lp));
      if (m_fp) chk("f_rdata", 64'(f_rd), 64'(m_rdata));
      if (m_lp) chk("l_rdata", 64'(l_rd), 64'(m_rdata));
      chk("conflict_cnt", 64'(cnt), 64'(m_cnt));
    end
    m_rdata = m_mem[sel[7:2]];
    if (rst) begin
      for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
      m_locked = 0; m_wait = 0; m_cnt = 0;
      m_fp = 0; m_lp = 0; m_valid = 1;
    end else begin
      if (el && l_wren)
        for (int b = 0; b < 4; b++)
          if (l_bmask[b]) m_mem[sel[7:2]][8*b +: 8] = l_wdata[8*b +: 8];
      m_fp = ef;
      m_lp = el && !l_wren;
      if (f_req && !ef && m_cnt < (1 << CW) - 1) m_cnt++;
      if (l_req && !el) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      else m_wait = 0;
      m_locked = m_locked ? l_lock : (el && l_lock);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            fr, lr, lw, lk;
    logic [AW-1:0] la;
    bit            ef, el;
    int            ecnt;
  } vec_t;

  function automatic vec_t mk(bit fr, bit lr, bit lw, bit lk,
                              logic [AW-1:0] la, bit ef, bit el, int ec);
    vec_t v;
    v.fr = fr; v.lr = lr; v.lw = lw; v.lk = lk; v.la = la;
    v.ef = ef; v.el = el; v.ecnt = ec;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    for (int i = 0; i < 4; i++) tbl[i] = mk(1, 1, 0, 0, 16'h30, 1, 0, 0);
    tbl[4] = mk(1, 1, 0, 0, 16'h30, 0, 1, 0);
    for (int i = 5; i < 9; i++) tbl[i] = mk(1, 1, 0, 0, 16'h30, 1, 0, 1);
    tbl[9]  = mk(1, 1, 0, 0, 16'h30, 0, 1, 1);
    tbl[10] = mk(1, 0, 0, 0, 16'h00, 1, 0, 2);
    for (int i = 11; i < 15; i++) tbl[i] = mk(1, 1, 1, 1, 16'h20, 1, 0, 2);
    tbl[15] = mk(1, 1, 1, 1, 16'h20, 0, 1, 2);
    tbl[16] = mk(1, 1, 1, 1, 16'h24, 0, 1, 3);
    tbl[17] = mk(1, 1, 1, 1, 16'h28, 0, 1, 4);
    tbl[18] = mk(1, 0, 0, 0, 16'h00, 0, 0, 5);
    tbl[19] = mk(1, 0, 0, 0, 16'h00, 1, 0, 6);

    rst = 1'b1;
    drive(0, '0, 0, 0, '0, '0, '0, 0);
    tick();
    rst = 1'b0;

    // Fetch-only stream
    drive(1, 16'h0, 0, 0, '0, '0, '0, 0);
    tick();
    chk("rst_f_rvalid", 64'(s_frv), 64'd0);
    chk("rst_l_rvalid", 64'(s_lrv), 64'd0);
    chk("rst_cnt", 64'(s_cnt), 64'd0);
    chk("fs_gnt0", 64'(s_fg), 64'd1);
    drive(1, 16'h4, 0, 0, '0, '0, '0, 0);
    tick();
    chk("fs_gnt1", 64'(s_fg), 64'd1);
    chk("fs_rv1", 64'(s_frv), 64'd1);
    chk("fs_rd1", 64'(s_frd), 64'h11);
    drive(1, 16'h8, 0, 0, '0, '0, '0, 0);
    tick();
    chk("fs_gnt2", 64'(s_fg), 64'd1);
    chk("fs_rd2", 64'(s_frd), 64'h22);
    drive(0, '0, 0, 0, '0, '0, '0, 0);
    tick();
    chk("fs_rv3", 64'(s_frv), 64'd1);
    chk("fs_rd3", 64'(s_frd), 64'h33);
    tick();
    chk("fs_rv4", 64'(s_frv), 64'd0);

    // Byte-masked write then read back
    drive(0, '0, 1, 1, 16'h10, 32'hDEADBEEF, 4'b0011, 0);
    tick();
    chk("wr_gnt", 64'(s_lg), 64'd1);
    chk("wr_wren", 64'(s_wren), 64'd1);
    drive(0, '0, 1, 0, 16'h10, '0, '0, 0);
    tick();
    chk("rd_gnt", 64'(s_lg), 64'd1);
    chk("wr_no_rv", 64'(s_lrv), 64'd0);
    drive(0, '0, 0, 0, '0, '0, '0, 0);
    tick();
    chk("rd_rv", 64'(s_lrv), 64'd1);
    chk("rd_data", 64'(s_lrd), 64'hAABBBEEF);

    // Starvation rotation and locked burst
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].fr, 16'(4 * i), tbl[i].lr, tbl[i].lw, tbl[i].la,
            32'hC0DE0000 | 32'(i), 4'hF, tbl[i].lk);
      tick();
      chk($sformatf("tbl%0d_fg", i), 64'(s_fg), 64'(tbl[i].ef));
      chk($sformatf("tbl%0d_lg", i), 64'(s_lg), 64'(tbl[i].el));
      chk($sformatf("tbl%0d_cnt", i), 64'(s_cnt), 64'(tbl[i].ecnt));
    end

    // Reset in the middle of a locked burst
    drive(0, '0, 1, 1, 16'h40, 32'h1234_5678, 4'hF, 1);
    tick();
    chk("lk_gnt", 64'(s_lg), 64'd1);
    drive(1, 16'h8, 1, 1, 16'h44, 32'h9ABC_DEF0, 4'hF, 1);
    tick();
    chk("lk_fblk", 64'(s_fg), 64'd0);
    chk("lk_lg", 64'(s_lg), 64'd1);
    rst = 1'b1;
    drive(1, 16'h8, 1, 0, 16'h10, '0, '0, 1);
    tick();
    chk("rst_lg", 64'(s_lg), 64'd1);
    chk("rst_fg", 64'(s_fg), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_f_rv", 64'(s_frv), 64'd0);
    chk("post_l_rv", 64'(s_lrv), 64'd0);
    chk("post_fg", 64'(s_fg), 64'd1);
    chk("post_lg", 64'(s_lg), 64'd0);
    chk("post_cnt", 64'(s_cnt), 64'd0);
    drive(0, '0, 0, 0, '0, '0, '0, 0);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(bit'($urandom_range(0, 1)), 16'($urandom),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            16'($urandom), $urandom, 4'($urandom),
            ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
